cpu_run_controller: RTL and testbench
=====================================

// Module: cpu_run_controller
// PURPOSE
//  Synthesizable successor to the CPU bench sequencer: resets the pipelined CPU, runs it until halt or timeout,
//  gates the CPU clock on halt, then streams register-file and data-memory contents out over a valid/ready port.
//  Sits between a host/bench and the PipelinedCPU; replaces fixed #delays and $writememh with a counted, parametrised dump.
// PARAMETERS
//  DATA_W          32    width of RF/DMEM read data and out_data
//  ADDR_W          32    width of rd_addr and out_addr (word index)
//  NUM_REGS        32    RF words dumped (0 = skip RF phase)
//  MEM_WORDS       1024  DMEM words dumped (0 = skip DMEM phase)
//  RESET_CYCLES    2     cycles cpu_rst held low after start (>=1)
//  DRAIN_CYCLES    4     idle cycles between halt/timeout and first dump beat
//  TIMEOUT_CYCLES  65536 RUN cycles before forced stop (0 = no timeout)
//  CNT_W           32    width of cycle_count (saturating)
// PORTS
//  clk          in   1       clock
//  rst          in   1       async active-low reset
//  start        in   1       1-cycle pulse; honoured only in IDLE or DONE
//  halt         in   1       CPU halt
//  cpu_rst      out  1       active-low reset to CPU
//  cpu_clk_en   out  1       CPU clock enable
//  rf_rd_addr   out  ADDR_W  RF read index (combinational read)
//  rf_rd_data   in   DATA_W  RF read data, same cycle
//  mem_rd_addr  out  ADDR_W  DMEM word index (combinational read)
//  mem_rd_data  in   DATA_W  DMEM read data, same cycle
//  out_valid    out  1       dump beat valid
//  out_ready    in   1       sink accepts beat
//  out_sel      out  1       0 = RF word, 1 = DMEM word
//  out_addr     out  ADDR_W  index of word in out_data
//  out_data     out  DATA_W  dumped word
//  out_last     out  1       final beat of the whole dump
//  cycle_count  out  CNT_W   RUN cycles elapsed
//  timeout      out  1       run ended by timeout, not halt
//  done         out  1       dump complete
// BEHAVIOUR
//  Reset (rst=0, async): state IDLE; cpu_rst=0, cpu_clk_en=0, out_valid=0, out_sel/addr/data/last=0,
//   rd addrs=0, cycle_count=0, timeout=0, done=0. Reset mid-dump drops out_valid immediately; the beat is lost.
//  FSM: IDLE -start-> RESET_CPU -> RUN -> DRAIN -> DUMP_RF -> DUMP_MEM -> DONE -start-> RESET_CPU.
//  RESET_CPU: cpu_rst=0, cpu_clk_en=1 for exactly RESET_CYCLES cycles; clears cycle_count, timeout, done on entry.
//   halt ignored.
//  RUN: cpu_rst=1, cpu_clk_en=1. Each cycle with halt=0, cycle_count++ (saturate at all-ones).
//   halt=1 -> DRAIN; cpu_clk_en=0 from the next cycle on.
//   halt=0 and cycle_count==TIMEOUT_CYCLES-1 (TIMEOUT_CYCLES!=0): count reaches TIMEOUT_CYCLES, timeout=1, -> DRAIN.
//   halt and timeout in the same cycle: halt wins, timeout stays 0.
//  DRAIN: cpu_clk_en=0, cpu_rst=1 (held until next start); wait DRAIN_CYCLES, then first non-empty dump phase,
//   or DONE if both NUM_REGS and MEM_WORDS are 0.
//  Dump: idx = next word to load; rd_addr = idx. Slot free = !out_valid | out_ready.
//   When free and words remain, register {sel, idx, rd_data} into out_*, out_valid=1, idx++ (one beat/cycle at full rate).
//   While out_valid & !out_ready all out_* and rd_addr hold stable. After the last RF load go to DUMP_MEM with idx=0.
//   out_last=1 only on the final beat overall. Accept of last beat -> DONE; out_valid=0 next cycle.
//  DONE: done=1; cycle_count/timeout held for readout. start in RUN/DRAIN/DUMP ignored.
//  Widths: out_addr zero-extended idx; idx counter sized $clog2(max(NUM_REGS,MEM_WORDS)+1).
// TESTING
//  1 RESET_CYCLES=2, start, halt raised on 11th RUN cycle -> cpu_rst low exactly 2 cycles, cycle_count=10,
//    timeout=0, cpu_clk_en=0 one cycle after halt.
//  2 TIMEOUT_CYCLES=16, halt never asserted -> timeout=1, cycle_count=16, dump still runs, done=1.
//  3 NUM_REGS=4, MEM_WORDS=4, out_ready=1 -> 8 back-to-back beats: sel 0,0,0,0,1,1,1,1; addr 0..3 twice;
//    data matches RF/DMEM; out_last on beat 8 only; done next cycle.
//  4 out_ready low 5 cycles mid-RF dump -> out_* stable throughout; no beat dropped or duplicated (8 total).
//  5 rst=0 during DUMP_MEM beat 2 -> out_valid=0 and cpu_rst=0 before next clk edge; state IDLE;
//    fresh start repeats full sequence.
//  6 halt and cycle_count==TIMEOUT_CYCLES-1 same cycle -> timeout=0; NUM_REGS=0 -> first beat has sel=1, addr 0.

Source files
------------

// File: rtl/cpu_run_controller.sv
// Run controller for the pipelined CPU: reset, run to halt/timeout,
// gate the CPU clock, then stream RF and DMEM words over valid/ready.
module cpu_run_controller #(
    parameter int DATA_W         = 32,
    parameter int ADDR_W         = 32,
    parameter int NUM_REGS       = 32,
    parameter int MEM_WORDS      = 1024,
    parameter int RESET_CYCLES   = 2,
    parameter int DRAIN_CYCLES   = 4,
    parameter int TIMEOUT_CYCLES = 65536,
    parameter int CNT_W          = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              halt,
    output logic              cpu_rst,
    output logic              cpu_clk_en,
    output logic [ADDR_W-1:0] rf_rd_addr,
    input  logic [DATA_W-1:0] rf_rd_data,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_sel,
    output logic [ADDR_W-1:0] out_addr,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic [CNT_W-1:0]  cycle_count,
    output logic              timeout,
    output logic              done
);

    localparam int MAX_W = (NUM_REGS > MEM_WORDS) ? NUM_REGS : MEM_WORDS;
    localparam int IDX_W = (MAX_W > 0) ? $clog2(MAX_W + 1) : 1;
    localparam logic [IDX_W-1:0] RF_LAST  = IDX_W'(NUM_REGS - 1);
    localparam logic [IDX_W-1:0] MEM_LAST = IDX_W'(MEM_WORDS - 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [31:0] RST_LAST = 32'(RESET_CYCLES - 1);
    localparam logic [31:0] DRN_LAST = 32'(DRAIN_CYCLES - 1);
    localparam bit HAS_RF  = (NUM_REGS != 0);
    localparam bit HAS_MEM = (MEM_WORDS != 0);
    localparam bit HAS_TMO = (TIMEOUT_CYCLES != 0);

    typedef enum logic [2:0] {
        IDLE, RESET_CPU, RUN, DRAIN, DUMP_RF, DUMP_MEM, DONE
    } state_t;

    state_t state, next_state;

    logic [31:0]       cnt;
    logic [IDX_W-1:0]  idx;
    logic [ADDR_W-1:0] idx_ext;
    logic              more;
    logic              dump_st, slot_free, ld, fin;
    logic              rf_end, mem_end, last_ld;
    logic              tmo_hit, go, drain_end;

    always_comb begin
        idx_ext = '0;
        idx_ext[IDX_W-1:0] = idx;
    end

    assign rf_rd_addr  = idx_ext;
    assign mem_rd_addr = idx_ext;
    assign cpu_rst     = !(state == IDLE || state == RESET_CPU);
    assign cpu_clk_en  = (state == RESET_CPU) || (state == RUN);
    assign done        = (state == DONE);

    assign dump_st   = (state == DUMP_RF) || (state == DUMP_MEM);
    assign slot_free = !out_valid || out_ready;
    assign ld        = dump_st && slot_free && more;
    assign fin       = dump_st && !more && out_valid && out_ready;
    assign rf_end    = (state == DUMP_RF) && (idx == RF_LAST);
    assign mem_end   = (state == DUMP_MEM) && (idx == MEM_LAST);
    assign last_ld   = ld && ((rf_end && !HAS_MEM) || mem_end);
    assign go        = start && (state == IDLE || state == DONE);
    assign drain_end = (DRAIN_CYCLES == 0) || (cnt == DRN_LAST);
    // halt has priority: a halting cycle never counts toward the timeout
    assign tmo_hit   = (state == RUN) && !halt && HAS_TMO &&
                       (cycle_count == TMO_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= next_state;
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:      if (start) next_state = RESET_CPU;
            RESET_CPU: if (cnt == RST_LAST) next_state = RUN;
            RUN:       if (halt || tmo_hit) next_state = DRAIN;
            DRAIN: begin
                if (drain_end) begin
                    if (HAS_RF)       next_state = DUMP_RF;
                    else if (HAS_MEM) next_state = DUMP_MEM;
                    else              next_state = DONE;
                end
            end
            DUMP_RF: begin
                if (fin)                          next_state = DONE;
                else if (ld && rf_end && HAS_MEM) next_state = DUMP_MEM;
            end
            DUMP_MEM:  if (fin) next_state = DONE;
            DONE:      if (start) next_state = RESET_CPU;
            default:   next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt         <= '0;
            idx         <= '0;
            more        <= 1'b0;
            cycle_count <= '0;
            timeout     <= 1'b0;
            out_valid   <= 1'b0;
            out_sel     <= 1'b0;
            out_addr    <= '0;
            out_data    <= '0;
            out_last    <= 1'b0;
        end else begin
            if (next_state != state)
                cnt <= '0;
            else if (state == RESET_CPU || state == DRAIN)
                cnt <= cnt + 32'd1;

            if (go) begin
                cycle_count <= '0;
                timeout     <= 1'b0;
            end else if (state == RUN && !halt) begin
                if (cycle_count != '1)
                    cycle_count <= cycle_count + 1'b1;
                if (tmo_hit)
                    timeout <= 1'b1;
            end

            if (state == DRAIN && next_state != DRAIN) begin
                idx  <= '0;
                more <= HAS_RF || HAS_MEM;
            end

            if (ld) begin
                out_valid <= 1'b1;
                out_sel   <= (state == DUMP_MEM);
                out_addr  <= idx_ext;
                out_data  <= (state == DUMP_MEM) ? mem_rd_data : rf_rd_data;
                out_last  <= last_ld;
                idx       <= rf_end ? '0 : idx + 1'b1;
                if (last_ld) more <= 1'b0;
            end else if (fin) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cpu_run_controller.sv
// Directed bench for cpu_run_controller: run/halt, timeout, dump
// back-to-back and stalled, reset mid-dump, halt/timeout tie.
module tb_cpu_run_controller;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        a_start, a_halt, a_ready;
    logic        a_cpu_rst, a_clk_en, a_valid, a_sel, a_last;
    logic        a_timeout, a_done;
    logic [31:0] a_rf_addr, a_rf_data, a_mem_addr, a_mem_data;
    logic [31:0] a_addr, a_data, a_count;

    logic        b_start, b_halt, b_ready;
    logic        b_cpu_rst, b_clk_en, b_valid, b_sel, b_last;
    logic        b_timeout, b_done;
    logic [31:0] b_rf_addr, b_rf_data, b_mem_addr, b_mem_data;
    logic [31:0] b_addr, b_data, b_count;

    int vecs = 0;
    int errs = 0;

    function automatic logic [31:0] word(input logic sel,
                                         input logic [31:0] a);
        return sel ? (32'hB000_0000 + a * 32'd17)
                   : (32'hA000_0000 + a);
    endfunction

    assign a_rf_data  = word(1'b0, a_rf_addr);
    assign a_mem_data = word(1'b1, a_mem_addr);
    assign b_rf_data  = word(1'b0, b_rf_addr);
    assign b_mem_data = word(1'b1, b_mem_addr);

    cpu_run_controller #(
        .NUM_REGS(4), .MEM_WORDS(4), .RESET_CYCLES(2),
        .DRAIN_CYCLES(4), .TIMEOUT_CYCLES(16)
    ) dut_a (
        .clk(clk), .rst(rst), .start(a_start), .halt(a_halt),
        .cpu_rst(a_cpu_rst), .cpu_clk_en(a_clk_en),
        .rf_rd_addr(a_rf_addr), .rf_rd_data(a_rf_data),
        .mem_rd_addr(a_mem_addr), .mem_rd_data(a_mem_data),
        .out_valid(a_valid), .out_ready(a_ready), .out_sel(a_sel),
        .out_addr(a_addr), .out_data(a_data), .out_last(a_last),
        .cycle_count(a_count), .timeout(a_timeout), .done(a_done)
    );

    cpu_run_controller #(
        .NUM_REGS(0), .MEM_WORDS(3), .RESET_CYCLES(2),
        .DRAIN_CYCLES(4), .TIMEOUT_CYCLES(16)
    ) dut_b (
        .clk(clk), .rst(rst), .start(b_start), .halt(b_halt),
        .cpu_rst(b_cpu_rst), .cpu_clk_en(b_clk_en),
        .rf_rd_addr(b_rf_addr), .rf_rd_data(b_rf_data),
        .mem_rd_addr(b_mem_addr), .mem_rd_data(b_mem_data),
        .out_valid(b_valid), .out_ready(b_ready), .out_sel(b_sel),
        .out_addr(b_addr), .out_data(b_data), .out_last(b_last),
        .cycle_count(b_count), .timeout(b_timeout), .done(b_done)
    );

    task automatic test_reset();
        rst = 1'b0;
        a_start = 0; a_halt = 0; a_ready = 0;
        b_start = 0; b_halt = 0; b_ready = 0;
        repeat (2) @(negedge clk);
        vecs++;
        if ({a_cpu_rst, a_clk_en, a_valid, a_sel, a_last,
             a_timeout, a_done} !== 7'b0) begin
            errs++;
            $display("FAIL reset_flags: got %b want 0000000",
                     {a_cpu_rst, a_clk_en, a_valid, a_sel, a_last,
                      a_timeout, a_done});
        end
        vecs++;
        if ({a_addr, a_data, a_count, a_rf_addr} !== 128'd0) begin
            errs++;
            $display("FAIL reset_words: addr %h data %h cnt %h rd %h want 0",
                     a_addr, a_data, a_count, a_rf_addr);
        end
        rst = 1'b1;
    endtask

    task automatic test_halt_run();
        int n;
        @(negedge clk); a_start = 1'b1;
        @(negedge clk); a_start = 1'b0;
        vecs++;
        if (a_clk_en !== 1'b1 || a_done !== 1'b0) begin
            errs++;
            $display("FAIL rstcpu_en: clk_en %b done %b want 1 0",
                     a_clk_en, a_done);
        end
        n = 0;
        while (a_cpu_rst === 1'b0 && n < 20) begin
            n++;
            @(negedge clk);
        end
        vecs++;
        if (n != 2) begin
            errs++;
            $display("FAIL rst_low: got %0d cycles want 2", n);
        end
        vecs++;
        if (a_count !== 32'd0 || a_clk_en !== 1'b1) begin
            errs++;
            $display("FAIL run_start: cnt %0d en %b want 0 1",
                     a_count, a_clk_en);
        end
        repeat (10) @(negedge clk);
        a_halt = 1'b1;
        vecs++;
        if (a_clk_en !== 1'b1) begin
            errs++;
            $display("FAIL halt_cycle_en: got %b want 1", a_clk_en);
        end
        @(negedge clk);
        a_halt = 1'b0;
        vecs++;
        if ({a_clk_en, a_cpu_rst, a_timeout} !== 3'b010 ||
            a_count !== 32'd10) begin
            errs++;
            $display("FAIL halt_stop: en/rst/tmo %b cnt %0d want 010 10",
                     {a_clk_en, a_cpu_rst, a_timeout}, a_count);
        end
    endtask

    task automatic test_dump(input int stall_at);
        int w, k, stall, cyc;
        logic [65:0] saved, now, want;
        a_ready = 1'b1;
        w = 0;
        while (!a_valid && w < 50) begin
            @(negedge clk);
            w++;
        end
        vecs++;
        if (w != 5) begin
            errs++;
            $display("FAIL drain_lat: got %0d want 5", w);
        end
        k = 0; stall = 0; cyc = 0; saved = '0;
        while (k < 8 && cyc < 100) begin
            now = {a_sel, a_addr, a_data, a_last};
            if (stall > 0) begin
                vecs++;
                if (a_valid !== 1'b1 || now !== saved) begin
                    errs++;
                    $display("FAIL stall_hold: v %b got %h want %h",
                             a_valid, now, saved);
                end
                stall--;
                if (stall == 0) a_ready = 1'b1;
            end else if (a_valid) begin
                want = {(k >= 4), 32'(k % 4),
                        word(k >= 4, 32'(k % 4)), (k == 7)};
                vecs++;
                if (now !== want) begin
                    errs++;
                    $display("FAIL beat%0d: got %h want %h", k, now, want);
                end
                if (k == stall_at) begin
                    saved = now;
                    a_ready = 1'b0;
                    stall = 5;
                end
                k++;
            end
            cyc++;
            @(negedge clk);
        end
        vecs++;
        if (cyc != ((stall_at < 0) ? 8 : 13) || k != 8) begin
            errs++;
            $display("FAIL beat_cycles: got %0d cyc %0d beats", cyc, k);
        end
        vecs++;
        if (a_done !== 1'b1 || a_valid !== 1'b0) begin
            errs++;
            $display("FAIL dump_done: done %b valid %b want 1 0",
                     a_done, a_valid);
        end
    endtask

    task automatic test_timeout();
        int w;
        @(negedge clk); a_start = 1'b1;
        @(negedge clk); a_start = 1'b0;
        vecs++;
        if (a_done !== 1'b0 || a_count !== 32'd0) begin
            errs++;
            $display("FAIL restart_clr: done %b cnt %0d want 0 0",
                     a_done, a_count);
        end
        w = 0;
        while (a_cpu_rst !== 1'b1 && w < 20) begin
            @(negedge clk);
            w++;
        end
        repeat (3) @(negedge clk);
        a_start = 1'b1;
        @(negedge clk); a_start = 1'b0;
        vecs++;
        if (a_cpu_rst !== 1'b1 || a_clk_en !== 1'b1) begin
            errs++;
            $display("FAIL start_ignored: rst %b en %b want 1 1",
                     a_cpu_rst, a_clk_en);
        end
        w = 0;
        while (a_clk_en !== 1'b0 && w < 100) begin
            @(negedge clk);
            w++;
        end
        vecs++;
        if (a_timeout !== 1'b1 || a_count !== 32'd16) begin
            errs++;
            $display("FAIL timeout: tmo %b cnt %0d want 1 16",
                     a_timeout, a_count);
        end
        test_dump(2);
        vecs++;
        if (a_timeout !== 1'b1 || a_count !== 32'd16) begin
            errs++;
            $display("FAIL done_hold: tmo %b cnt %0d want 1 16",
                     a_timeout, a_count);
        end
    endtask

    task automatic test_reset_mid_dump();
        int w;
        @(negedge clk); a_start = 1'b1;
        @(negedge clk); a_start = 1'b0;
        w = 0;
        while (a_cpu_rst !== 1'b1 && w < 20) begin
            @(negedge clk);
            w++;
        end
        repeat (2) @(negedge clk);
        a_halt = 1'b1;
        @(negedge clk); a_halt = 1'b0;
        a_ready = 1'b1;
        w = 0;
        while (!(a_valid && a_sel && a_addr == 32'd1) && w < 60) begin
            @(negedge clk);
            w++;
        end
        vecs++;
        if (w >= 60) begin
            errs++;
            $display("FAIL mem_beat2: got no beat in %0d cycles want it", w);
        end
        rst = 1'b0;
        #1;
        vecs++;
        if ({a_valid, a_cpu_rst, a_clk_en, a_done} !== 4'b0 ||
            a_count !== 32'd0) begin
            errs++;
            $display("FAIL async_rst: v/rst/en/done %b cnt %0d want 0000 0",
                     {a_valid, a_cpu_rst, a_clk_en, a_done}, a_count);
        end
        @(negedge clk); rst = 1'b1;
        @(negedge clk);
        vecs++;
        if ({a_valid, a_cpu_rst, a_clk_en} !== 3'b0) begin
            errs++;
            $display("FAIL idle_hold: got %b want 000",
                     {a_valid, a_cpu_rst, a_clk_en});
        end
        test_halt_run();
        test_dump(-1);
    endtask

    task automatic test_b_tie();
        int w, k;
        logic [65:0] now, want;
        @(negedge clk); b_start = 1'b1;
        @(negedge clk); b_start = 1'b0;
        w = 0;
        while (b_count !== 32'd15 && w < 100) begin
            @(negedge clk);
            w++;
        end
        b_halt = 1'b1;
        @(negedge clk); b_halt = 1'b0;
        vecs++;
        if (b_timeout !== 1'b0 || b_count !== 32'd15 ||
            b_clk_en !== 1'b0) begin
            errs++;
            $display("FAIL tie: tmo %b cnt %0d en %b want 0 15 0",
                     b_timeout, b_count, b_clk_en);
        end
        b_ready = 1'b1;
        w = 0;
        while (!b_valid && w < 50) begin
            @(negedge clk);
            w++;
        end
        k = 0;
        while (k < 3 && w < 100) begin
            now = {b_sel, b_addr, b_data, b_last};
            want = {1'b1, 32'(k), word(1'b1, 32'(k)), (k == 2)};
            vecs++;
            if (b_valid !== 1'b1 || now !== want) begin
                errs++;
                $display("FAIL b_beat%0d: v %b got %h want %h",
                         k, b_valid, now, want);
            end
            k++;
            w++;
            @(negedge clk);
        end
        vecs++;
        if (b_done !== 1'b1 || b_valid !== 1'b0) begin
            errs++;
            $display("FAIL b_done: done %b valid %b want 1 0",
                     b_done, b_valid);
        end
    endtask

    initial begin
        test_reset();
        test_halt_run();
        test_dump(-1);
        test_timeout();
        test_reset_mid_dump();
        test_b_tie();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
